// File: rtl/regfile_pkg.sv
// Shared constants, controller state type and lane-masking helper for the
// register-block port controller.
package regfile_pkg;

    localparam int NUM_LANES    = 16;
    localparam int DATA_W       = 32;
    localparam int NUM_REGS     = 16;
    localparam int NUM_WARPS    = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int RA_W         = $clog2(NUM_REGS);
    localparam int WS_W         = $clog2(NUM_WARPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } rf_state_e;

    // Returns the lane word when the lane is kept, zero otherwise.
    function automatic logic [DATA_W-1:0] lane_word(input logic keep, input logic [DATA_W-1:0] word);
        lane_word = keep ? word : {DATA_W{1'b0}};
    endfunction

endpackage

// File: rtl/regfile_port_ctrl.sv
// Sole driver of register_block ports: serialises writeback and operand reads on the
// shared warp selector (writes first, reads guaranteed after a bounded number of losses).
module regfile_port_ctrl #(
    parameter int NUM_LANES    = regfile_pkg::NUM_LANES,
    parameter int DATA_W       = regfile_pkg::DATA_W,
    parameter int NUM_REGS     = regfile_pkg::NUM_REGS,
    parameter int NUM_WARPS    = regfile_pkg::NUM_WARPS,
    parameter int STARVE_LIMIT = regfile_pkg::STARVE_LIMIT,
    localparam int RA_W        = $clog2(NUM_REGS),
    localparam int WS_W        = $clog2(NUM_WARPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iss_valid,
    output logic                          iss_ready,
    input  logic [WS_W-1:0]               iss_warp,
    input  logic [RA_W-1:0]               iss_rs0,
    input  logic [RA_W-1:0]               iss_rs1,
    input  logic [1:0]                    iss_src_mask,
    input  logic [NUM_LANES-1:0]          iss_lane_mask,
    output logic                          op_valid,
    input  logic                          op_ready,
    output logic [WS_W-1:0]               op_warp,
    output logic [NUM_LANES-1:0]          op_lane_mask,
    output logic [NUM_LANES*DATA_W-1:0]   op_src0,
    output logic [NUM_LANES*DATA_W-1:0]   op_src1,
    input  logic                          wb_valid,
    output logic                          wb_ready,
    input  logic [WS_W-1:0]               wb_warp,
    input  logic [RA_W-1:0]               wb_addr,
    input  logic [NUM_LANES-1:0]          wb_lane_mask,
    input  logic [NUM_LANES*DATA_W-1:0]   wb_data,
    output logic [NUM_LANES-1:0]          rf_read_en_0,
    output logic [NUM_LANES-1:0]          rf_read_en_1,
    output logic [RA_W-1:0]               rf_raddr_0,
    output logic [RA_W-1:0]               rf_raddr_1,
    output logic [NUM_LANES-1:0]          rf_write_en,
    output logic [RA_W-1:0]               rf_waddr,
    output logic [NUM_LANES*DATA_W-1:0]   rf_wdata,
    output logic [WS_W-1:0]               rf_warp_selector,
    input  logic [NUM_LANES*DATA_W-1:0]   rf_rdata_0,
    input  logic [NUM_LANES*DATA_W-1:0]   rf_rdata_1
);
    import regfile_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STARVE_LIMIT);

    rf_state_e                  state_r, state_s;
    logic [CNT_W-1:0]           stall_cnt_r, stall_cnt_s;
    logic [WS_W-1:0]            req_warp_r;
    logic [RA_W-1:0]            req_rs0_r, req_rs1_r;
    logic [1:0]                 req_src_r;
    logic [NUM_LANES-1:0]       req_lanes_r;
    logic                       op_valid_r;
    logic [WS_W-1:0]            op_warp_r;
    logic [NUM_LANES-1:0]       op_lanes_r;
    logic [NUM_LANES*DATA_W-1:0] op_src0_r, op_src1_r;
    logic [NUM_LANES*DATA_W-1:0] cap0_s, cap1_s;
    logic                       read_go_s, write_go_s, iss_ready_s, accept_s;

    // Arbitration: a pending read loses to writeback until it has lost STARVE_LIMIT times.
    always_comb begin
        read_go_s = 1'b0;
        if ((state_r == READ) && !rst) begin
            if (wb_valid && (stall_cnt_r < STALL_MAX)) begin
                read_go_s = 1'b0;
            end else begin
                read_go_s = 1'b1;
            end
        end else begin
            read_go_s = 1'b0;
        end
        write_go_s = wb_valid && !rst && !read_go_s;
    end

    assign wb_ready = !rst && !read_go_s;

    // Register-block port drive: write, read, or all zero.
    always_comb begin
        rf_read_en_0     = {NUM_LANES{1'b0}};
        rf_read_en_1     = {NUM_LANES{1'b0}};
        rf_raddr_0       = {RA_W{1'b0}};
        rf_raddr_1       = {RA_W{1'b0}};
        rf_write_en      = {NUM_LANES{1'b0}};
        rf_waddr         = {RA_W{1'b0}};
        rf_wdata         = {(NUM_LANES*DATA_W){1'b0}};
        rf_warp_selector = {WS_W{1'b0}};
        if (write_go_s) begin
            rf_write_en      = wb_lane_mask;
            rf_waddr         = wb_addr;
            rf_wdata         = wb_data;
            rf_warp_selector = wb_warp;
        end else if (read_go_s) begin
            rf_read_en_0     = req_src_r[0] ? req_lanes_r : {NUM_LANES{1'b0}};
            rf_read_en_1     = req_src_r[1] ? req_lanes_r : {NUM_LANES{1'b0}};
            rf_raddr_0       = req_rs0_r;
            rf_raddr_1       = req_rs1_r;
            rf_warp_selector = req_warp_r;
        end else begin
            rf_warp_selector = {WS_W{1'b0}};
        end
    end

    // Operand capture: inactive lanes and unrequested sources become zero.
    always_comb begin
        cap0_s = {(NUM_LANES*DATA_W){1'b0}};
        cap1_s = {(NUM_LANES*DATA_W){1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            cap0_s[i*DATA_W +: DATA_W] = lane_word(req_src_r[0] && req_lanes_r[i], rf_rdata_0[i*DATA_W +: DATA_W]);
            cap1_s[i*DATA_W +: DATA_W] = lane_word(req_src_r[1] && req_lanes_r[i], rf_rdata_1[i*DATA_W +: DATA_W]);
        end
    end

    // Next-state and issue handshake.
    always_comb begin
        state_s     = state_r;
        stall_cnt_s = stall_cnt_r;
        iss_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                iss_ready_s = 1'b1;
                if (iss_valid) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (read_go_s) begin
                    state_s     = HOLD;
                    stall_cnt_s = {CNT_W{1'b0}};
                end else begin
                    stall_cnt_s = stall_cnt_r + CNT_W'(1'b1);
                end
            end
            HOLD: begin
                iss_ready_s = op_ready;
                if (op_ready) begin
                    state_s = iss_valid ? READ : IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s     = IDLE;
                stall_cnt_s = {CNT_W{1'b0}};
            end
        endcase
        accept_s = iss_valid && iss_ready_s;
    end

    assign iss_ready = iss_ready_s;

    // State, latched request and held operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            stall_cnt_r <= {CNT_W{1'b0}};
            req_warp_r  <= {WS_W{1'b0}};
            req_rs0_r   <= {RA_W{1'b0}};
            req_rs1_r   <= {RA_W{1'b0}};
            req_src_r   <= 2'b00;
            req_lanes_r <= {NUM_LANES{1'b0}};
            op_valid_r  <= 1'b0;
            op_warp_r   <= {WS_W{1'b0}};
            op_lanes_r  <= {NUM_LANES{1'b0}};
            op_src0_r   <= {(NUM_LANES*DATA_W){1'b0}};
            op_src1_r   <= {(NUM_LANES*DATA_W){1'b0}};
        end else begin
            state_r     <= state_s;
            stall_cnt_r <= stall_cnt_s;
            if (accept_s) begin
                req_warp_r  <= iss_warp;
                req_rs0_r   <= iss_rs0;
                req_rs1_r   <= iss_rs1;
                req_src_r   <= iss_src_mask;
                req_lanes_r <= iss_lane_mask;
            end
            if (read_go_s) begin
                op_valid_r <= 1'b1;
                op_warp_r  <= req_warp_r;
                op_lanes_r <= req_lanes_r;
                op_src0_r  <= cap0_s;
                op_src1_r  <= cap1_s;
            end else if (op_valid_r && op_ready) begin
                op_valid_r <= 1'b0;
            end
        end
    end

    assign op_valid     = op_valid_r;
    assign op_warp      = op_warp_r;
    assign op_lane_mask = op_lanes_r;
    assign op_src0      = op_src0_r;
    assign op_src1      = op_src1_r;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Randomized and directed bench for regfile_port_ctrl against a request-level
// reference model and a behavioural register_block.
module tb_regfile_port_ctrl;

    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int NR    = 16;
    localparam int NW    = 8;
    localparam int RA    = 4;
    localparam int WS    = 3;
    localparam int LIM   = 4;
    localparam int BUSW  = LANES * DW;

    logic clk, rst;
    logic iss_valid, iss_ready, op_valid, op_ready, wb_valid, wb_ready;
    logic [WS-1:0] iss_warp, op_warp, wb_warp, rf_warp_selector;
    logic [RA-1:0] iss_rs0, iss_rs1, wb_addr, rf_raddr_0, rf_raddr_1, rf_waddr;
    logic [1:0] iss_src_mask;
    logic [LANES-1:0] iss_lane_mask, op_lane_mask, wb_lane_mask;
    logic [LANES-1:0] rf_read_en_0, rf_read_en_1, rf_write_en;
    logic [BUSW-1:0] op_src0, op_src1, wb_data, rf_wdata, rf_rdata_0, rf_rdata_1;

    regfile_port_ctrl dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_warp(iss_warp),
        .iss_rs0(iss_rs0), .iss_rs1(iss_rs1), .iss_src_mask(iss_src_mask),
        .iss_lane_mask(iss_lane_mask),
        .op_valid(op_valid), .op_ready(op_ready), .op_warp(op_warp),
        .op_lane_mask(op_lane_mask), .op_src0(op_src0), .op_src1(op_src1),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_addr(wb_addr),
        .wb_lane_mask(wb_lane_mask), .wb_data(wb_data),
        .rf_read_en_0(rf_read_en_0), .rf_read_en_1(rf_read_en_1),
        .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
        .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_warp_selector(rf_warp_selector),
        .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register_block contents as written by the DUT, and the reference contents
    logic [DW-1:0] rfm  [NW][NR][LANES];
    logic [DW-1:0] gold [NW][NR][LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rf_rdata_0[l*DW +: DW] = rfm[rf_warp_selector][rf_raddr_0][l];
            rf_rdata_1[l*DW +: DW] = rfm[rf_warp_selector][rf_raddr_1][l];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // reference model: one pending request, one held result
    bit m_pend, m_hold;
    int m_stall;
    logic [WS-1:0] m_warp, m_op_warp;
    logic [RA-1:0] m_rs0, m_rs1;
    logic [1:0] m_src;
    logic [LANES-1:0] m_lanes, m_op_lanes;
    logic [BUSW-1:0] m_op0, m_op1;

    logic obs_wb_ready, obs_iss_ready;
    logic [LANES-1:0] obs_re0, obs_re1;
    logic [RA-1:0] obs_ra0, obs_ra1;
    logic [WS-1:0] obs_sel;

    task automatic check(input string tag, input logic [BUSW-1:0] got, input logic [BUSW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int w, input int r, input int l, input logic [DW-1:0] v);
        rfm[w][r][l]  = v;
        gold[w][r][l] = v;
    endtask

    task automatic rand_wb();
        wb_warp      = WS'($urandom_range(0, NW-1));
        wb_addr      = RA'($urandom_range(0, NR-1));
        wb_lane_mask = LANES'($urandom);
        for (int l = 0; l < LANES; l++) wb_data[l*DW +: DW] = $urandom;
    endtask

    task automatic rand_iss();
        iss_warp      = WS'($urandom_range(0, NW-1));
        iss_rs0       = RA'($urandom_range(0, NR-1));
        iss_rs1       = RA'($urandom_range(0, NR-1));
        iss_src_mask  = 2'($urandom_range(0, 3));
        iss_lane_mask = ($urandom_range(0, 2) == 0) ? 16'hFFFF : LANES'($urandom);
    endtask

    // One clock: check outputs against the model, then advance model and memories.
    task automatic step();
        logic rd_win, wr_go, iss_acc;
        logic [LANES-1:0] a_we;
        logic [WS-1:0] a_sel;
        logic [RA-1:0] a_wa;
        logic [BUSW-1:0] a_wd, e0, e1;
        #1;
        rd_win  = m_pend && !(wb_valid && (m_stall < LIM));
        wr_go   = wb_valid && !rd_win;
        iss_acc = iss_valid && !m_pend && (!m_hold || op_ready);
        check("iss_ready", iss_ready, !m_pend && (!m_hold || op_ready));
        check("wb_ready", wb_ready, !rd_win);
        check("op_valid", op_valid, m_hold);
        if (m_hold) begin
            check("op_warp", op_warp, m_op_warp);
            check("op_lane_mask", op_lane_mask, m_op_lanes);
            check("op_src0", op_src0, m_op0);
            check("op_src1", op_src1, m_op1);
        end
        check("rf_write_en", rf_write_en, wr_go ? wb_lane_mask : 16'h0000);
        check("rf_waddr", rf_waddr, wr_go ? wb_addr : 4'h0);
        check("rf_wdata", rf_wdata, wr_go ? wb_data : {BUSW{1'b0}});
        check("rf_read_en_0", rf_read_en_0, (rd_win && m_src[0]) ? m_lanes : 16'h0000);
        check("rf_read_en_1", rf_read_en_1, (rd_win && m_src[1]) ? m_lanes : 16'h0000);
        check("rf_warp_selector", rf_warp_selector, wr_go ? wb_warp : (rd_win ? m_warp : 3'd0));
        if (rd_win) begin
            if (m_src[0]) check("rf_raddr_0", rf_raddr_0, m_rs0);
            if (m_src[1]) check("rf_raddr_1", rf_raddr_1, m_rs1);
        end else begin
            check("rf_raddr_0 idle", rf_raddr_0, 4'h0);
            check("rf_raddr_1 idle", rf_raddr_1, 4'h0);
        end
        obs_wb_ready = wb_ready; obs_iss_ready = iss_ready;
        obs_re0 = rf_read_en_0; obs_re1 = rf_read_en_1;
        obs_ra0 = rf_raddr_0;   obs_ra1 = rf_raddr_1; obs_sel = rf_warp_selector;
        a_we = rf_write_en; a_sel = rf_warp_selector; a_wa = rf_waddr; a_wd = rf_wdata;
        e0 = '0; e1 = '0;
        for (int l = 0; l < LANES; l++) begin
            if (m_src[0] && m_lanes[l]) e0[l*DW +: DW] = gold[m_warp][m_rs0][l];
            if (m_src[1] && m_lanes[l]) e1[l*DW +: DW] = gold[m_warp][m_rs1][l];
        end
        @(posedge clk);
        for (int l = 0; l < LANES; l++) begin
            if (a_we[l]) rfm[a_sel][a_wa][l] = a_wd[l*DW +: DW];
            if (wr_go && wb_lane_mask[l]) gold[wb_warp][wb_addr][l] = wb_data[l*DW +: DW];
        end
        if (m_hold && op_ready) m_hold = 1'b0;
        if (rd_win) begin
            m_hold = 1'b1; m_pend = 1'b0; m_stall = 0;
            m_op_warp = m_warp; m_op_lanes = m_lanes; m_op0 = e0; m_op1 = e1;
        end else if (m_pend) begin
            m_stall++;
        end
        if (iss_acc) begin
            m_pend = 1'b1; m_warp = iss_warp; m_rs0 = iss_rs0; m_rs1 = iss_rs1;
            m_src = iss_src_mask; m_lanes = iss_lane_mask;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        iss_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
    endtask

    // Continuous writeback around one issue: the read must win after exactly LIM losses.
    task automatic starve_run(input string tag);
        int wr_before, lows;
        bit seen_low;
        wr_before = 0; lows = 0; seen_low = 0;
        op_ready = 1'b1; wb_valid = 1'b1; rand_wb();
        iss_valid = 1'b1; rand_iss();
        step();
        iss_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_wb();
            step();
            if (!obs_wb_ready) begin
                lows++; seen_low = 1;
            end else if (!seen_low) begin
                wr_before++;
            end
        end
        check({tag, " writes_before_read"}, wr_before, 4);
        check({tag, " read_cycles"}, lows, 1);
        wb_valid = 1'b0;
    endtask

    task automatic reset_now();
        rst = 1'b1; wb_valid = 1'b1; wb_lane_mask = 16'hFFFF; iss_valid = 1'b0;
        #1;
        check("rst op_valid", op_valid, 1'b0);
        check("rst iss_ready", iss_ready, 1'b1);
        check("rst rf_read_en_0", rf_read_en_0, 16'h0000);
        check("rst rf_read_en_1", rf_read_en_1, 16'h0000);
        check("rst rf_write_en", rf_write_en, 16'h0000);
        check("rst op_src0", op_src0, {BUSW{1'b0}});
        check("rst op_warp", op_warp, 3'd0);
        m_pend = 1'b0; m_hold = 1'b0; m_stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; wb_valid = 1'b0;
    endtask

    logic [DW-1:0] p_a [LANES];
    logic [DW-1:0] p_b [LANES];
    logic [BUSW-1:0] exp0, exp1;
    int wb_pct;

    initial begin
        rst = 1'b1; iss_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
        iss_warp = '0; iss_rs0 = '0; iss_rs1 = '0; iss_src_mask = '0; iss_lane_mask = '0;
        wb_warp = '0; wb_addr = '0; wb_lane_mask = '0; wb_data = '0;
        m_pend = 0; m_hold = 0; m_stall = 0;
        m_warp = '0; m_rs0 = '0; m_rs1 = '0; m_src = '0; m_lanes = '0;
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                for (int l = 0; l < LANES; l++) poke(w, r, l, $urandom);
        @(negedge clk);
        reset_now();

        // preloaded warp 3 r5/r9, both sources, all lanes
        drain();
        for (int l = 0; l < LANES; l++) begin
            p_a[l] = $urandom; p_b[l] = $urandom;
            poke(3, 5, l, p_a[l]); poke(3, 9, l, p_b[l]);
            exp0[l*DW +: DW] = p_a[l]; exp1[l*DW +: DW] = p_b[l];
        end
        op_ready = 1'b0; iss_valid = 1'b1; iss_warp = 3'd3; iss_rs0 = 4'd5; iss_rs1 = 4'd9;
        iss_src_mask = 2'b11; iss_lane_mask = 16'hFFFF;
        step();
        iss_valid = 1'b0;
        step();
        check("pre sel", obs_sel, 3'd3);
        check("pre raddr0", obs_ra0, 4'd5);
        check("pre raddr1", obs_ra1, 4'd9);
        check("pre op_valid", op_valid, 1'b1);
        check("pre src0", op_src0, exp0);
        check("pre src1", op_src1, exp1);

        // write priority with starvation bound
        drain();
        starve_run("starve");

        // read-after-write on warp 2 r7
        drain();
        op_ready = 1'b0; iss_valid = 1'b1; iss_warp = 3'd2; iss_rs0 = 4'd7; iss_rs1 = 4'd0;
        iss_src_mask = 2'b01; iss_lane_mask = 16'hFFFF;
        step();
        iss_valid = 1'b0; wb_valid = 1'b1; wb_warp = 3'd2; wb_addr = 4'd7; wb_lane_mask = 16'hFFFF;
        wb_data = {16{32'hA5A5A5A5}};
        step();
        wb_valid = 1'b0;
        step();
        check("raw src0", op_src0, {16{32'hA5A5A5A5}});

        // single source, half the lanes
        drain();
        for (int l = 0; l < LANES; l++) begin
            p_a[l] = $urandom; poke(6, 1, l, p_a[l]); poke(6, 2, l, $urandom);
        end
        exp0 = '0;
        for (int l = 0; l < 8; l++) exp0[l*DW +: DW] = p_a[l];
        op_ready = 1'b0; iss_valid = 1'b1; iss_warp = 3'd6; iss_rs0 = 4'd1; iss_rs1 = 4'd2;
        iss_src_mask = 2'b01; iss_lane_mask = 16'h00FF;
        step();
        iss_valid = 1'b0;
        step();
        check("mask read_en_0", obs_re0, 16'h00FF);
        check("mask read_en_1", obs_re1, 16'h0000);
        check("mask src1", op_src1, {BUSW{1'b0}});
        check("mask src0", op_src0, exp0);

        // hold with back-pressure, then back-to-back accept
        for (int k = 0; k < 5; k++) step();
        check("hold iss_ready", obs_iss_ready, 1'b0);
        check("hold op_valid", op_valid, 1'b1);
        op_ready = 1'b1; iss_valid = 1'b1; rand_iss();
        step();
        iss_valid = 1'b0;
        check("b2b gap op_valid", op_valid, 1'b0);
        step();
        check("b2b op_valid", op_valid, 1'b1);

        // reset while a read is pending and has already lost twice
        drain();
        op_ready = 1'b1; wb_valid = 1'b1; rand_wb(); iss_valid = 1'b1; rand_iss();
        step();
        iss_valid = 1'b0;
        rand_wb(); step();
        rand_wb(); step();
        reset_now();
        starve_run("post_reset");

        // randomized traffic
        drain();
        wb_pct = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) wb_pct = $urandom_range(0, 3) * 33 + 1;
            iss_valid = ($urandom_range(0, 99) < 45);
            rand_iss();
            if ($urandom_range(0, 1) == 1) begin
                iss_warp = WS'($urandom_range(0, 1));
                iss_rs0  = RA'($urandom_range(0, 3));
                iss_rs1  = RA'($urandom_range(0, 3));
            end
            wb_valid = ($urandom_range(0, 99) < wb_pct);
            rand_wb();
            if ($urandom_range(0, 1) == 1) begin
                wb_warp = WS'($urandom_range(0, 1));
                wb_addr = RA'($urandom_range(0, 3));
            end
            op_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Port controller that sits between the warp scheduler/writeback stage and `register_block`, and is the only agent driving its ports. It accepts one operand-read request at a time, performs the two-port read for the selected warp and registers all lanes of both operands toward the execute stage. It also forwards writeback requests to the write port. The read and write paths share the single `warp_selector`, so writes and reads are time-multiplexed, with writes prioritised and a bounded starvation guard for reads.

## Interface
Parameters:
- NUM_LANES, 16, lanes per warp (width of enable masks)
- DATA_W, 32, register width
- NUM_REGS, 16, registers per lane; address width RA_W = clog2(NUM_REGS)
- NUM_WARPS, 8, warps; WS_W = clog2(NUM_WARPS)
- STARVE_LIMIT, 4, maximum consecutive cycles a pending read may lose to writes

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- iss_valid / iss_ready  in / out  1  read-request handshake
- iss_warp  in  WS_W  warp to read
- iss_rs0, iss_rs1  in  RA_W  source register addresses
- iss_src_mask  in  2  bit0 = read rs0 on port 0; bit1 = read rs1 on port 1
- iss_lane_mask  in  NUM_LANES  active lanes
- op_valid / op_ready  out / in  1  operand handshake
- op_warp  out  WS_W  warp of the returned operands
- op_lane_mask  out  NUM_LANES  active lanes of the returned operands
- op_src0, op_src1  out  NUM_LANES*DATA_W  operands; lane i occupies bits [i*DATA_W +: DATA_W]
- wb_valid / wb_ready  in / out  1  writeback handshake
- wb_warp  in  WS_W  writeback warp
- wb_addr  in  RA_W  writeback register address
- wb_lane_mask  in  NUM_LANES  writeback lanes
- wb_data  in  NUM_LANES*DATA_W  writeback data
- rf_read_en_0, rf_read_en_1  out  NUM_LANES  register-block read enables
- rf_raddr_0, rf_raddr_1  out  RA_W  register-block read addresses
- rf_write_en  out  NUM_LANES  register-block write enable
- rf_waddr  out  RA_W  register-block write address
- rf_wdata  out  NUM_LANES*DATA_W  register-block write data
- rf_warp_selector  out  WS_W  register-block warp selector
- rf_rdata_0, rf_rdata_1  in  NUM_LANES*DATA_W  register-block read data, combinational with the read address

## Operation
States:
- IDLE: iss_ready=1. On accept, latch warp, rs0, rs1, src_mask and lane_mask, then go to READ.
- READ: a read is pending. If wb_valid=1 and stall_cnt<STARVE_LIMIT, the write wins, stall_cnt increments, and the state stays READ. Otherwise the read is performed: capture the operands, clear stall_cnt, go to HOLD.
- HOLD: op_valid=1. On op_ready=1, go to IDLE; if iss_valid=1 in the same cycle, go directly to READ instead (iss_ready=op_ready in HOLD).

Write port:
- wb_ready=1 in every cycle except a READ cycle in which the read wins.
- When wb_valid=1 and wb_ready=1: rf_write_en=wb_lane_mask, rf_waddr=wb_addr, rf_wdata=wb_data, rf_warp_selector=wb_warp. Otherwise rf_write_en=0.

Read port:
- In the winning READ cycle: rf_warp_selector=latched warp; rf_read_en_0=lane_mask if src_mask[0], else 0; same rule for port 1 with src_mask[1].
- Captured lanes that are outside lane_mask, and any source that was not requested, are stored as zero.
- All rf_* outputs are 0 whenever neither a read nor a write is driven.

Ordering: a write and a read never share a cycle. A write that completes before the winning read cycle is visible to that read (read-after-write ordering).

## Timing
- Reset values: state IDLE, stall_cnt 0, op_* all zero, op_valid 0; every rf_* output 0 while rst=1.
- Latency with no write contention: issue accepted at edge T, read cycle T..T+1, op_valid=1 after edge T+1. Each lost arbitration adds 1 cycle; worst case is STARVE_LIMIT extra cycles.
- op_* outputs are stable while op_valid=1 and op_ready=0.
- Reset asserted mid-operation: the pending request and held operands are discarded; no rf enable is driven while rst=1.

## Structure
- Shared package `regfile_pkg`: NUM_LANES, DATA_W, NUM_REGS, NUM_WARPS, derived RA_W/WS_W, the state enum (IDLE/READ/HOLD), and a lane-masking function.
- No sub-module: the FSM, arbiter and operand registers live in one module.

## Test plan
- Reset during READ with a pending request → next cycle op_valid=0, iss_ready=1, rf_read_en_0/1=0, stall_cnt=0.
- Preload warp 3 r5/r9; issue warp=3, rs0=5, rs1=9, src_mask=11, lanes=FFFF with no writes → one read cycle with rf_warp_selector=3, rf_raddr_0=5, rf_raddr_1=9; op_valid one edge later with exact preloaded data.
- wb_valid held high continuously, then one issue → exactly 4 write cycles, 1 cycle with wb_ready=0 for the read, then writes resume.
- Write warp 2 r7 = A5A5A5A5 (all lanes) while a read of warp 2 r7 is pending → op_src0 every lane = A5A5A5A5.
- src_mask=01, lane_mask=00FF → rf_read_en_0=00FF, rf_read_en_1=0; op_src1=0; op_src0 lanes 8–15 = 0.
- Hold op_ready=0 for 5 cycles → op_* stable, iss_ready=0; then op_ready=1 together with iss_valid=1 → back-to-back accept, next op_valid 2 edges later.
